// File: rtl/rc_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : rc_ctrl                                                        |
// | Purpose  : Read-cache responder for the ISU d_rc interface; executes     |
// |            LOAD / STORE / WAE against a local SETS x WAYS line array.    |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module rc_ctrl #(
  parameter int SETS       = 8,
  parameter int WAYS       = 4,
  parameter int CL_WIDTH   = 256,
  parameter int WORD_WIDTH = 128,
  parameter int ROB_W      = 4,
  parameter int WBUF_W     = 7,
  parameter int CHAN       = 3,
  localparam int SET_W     = $clog2(SETS),
  localparam int WAY_W     = $clog2(WAYS),
  localparam int OFF_W     = $clog2(CL_WIDTH / WORD_WIDTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  d_rc_valid,
  output logic                  d_rc_ready,
  input  logic [CHAN-1:0]       d_rc_channel_1hot_id,
  input  logic [ROB_W-1:0]      d_rc_rob_id,
  input  logic [2:0]            d_rc_op,
  input  logic [SET_W-1:0]      d_rc_set,
  input  logic [WAY_W-1:0]      d_rc_way,
  input  logic [OFF_W-1:0]      d_rc_offset,
  input  logic [WBUF_W-1:0]     d_rc_wbuf_id,
  input  logic [CL_WIDTH-1:0]   d_rc_refill_data,
  output logic                  wbuf_rd_valid,
  output logic [WBUF_W-1:0]     wbuf_rd_id,
  input  logic [WORD_WIDTH-1:0] wbuf_rd_data,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [CHAN-1:0]       rsp_channel_1hot_id,
  output logic [ROB_W-1:0]      rsp_rob_id,
  output logic [2:0]            rsp_op,
  output logic [WORD_WIDTH-1:0] rsp_data,
  output logic                  rsp_err,
  output logic [CHAN-1:0]       u_xbar_crdt_rtn
);

  localparam logic [2:0] CACHE_OP_LOAD  = 3'd0;
  localparam logic [2:0] CACHE_OP_STORE = 3'd1;
  localparam logic [2:0] CACHE_OP_WAE   = 3'd2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WBUF  = 2'd1,
    WRITE = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic                      r_rst_done;
  logic [CHAN-1:0]           r_chan;
  logic                      r_chan_ok;
  logic [ROB_W-1:0]          r_rob;
  logic [2:0]                r_op;
  logic [SET_W-1:0]          r_set;
  logic [WAY_W-1:0]          r_way;
  logic [OFF_W-1:0]          r_offset;
  logic [WBUF_W-1:0]         r_wbuf_id;
  logic [CL_WIDTH-1:0]       r_refill;
  logic [WORD_WIDTH-1:0]     r_rsp_data;
  logic                      r_rsp_err;
  logic [CHAN-1:0]           r_crdt;
  logic [CL_WIDTH-1:0]       r_mem [SETS*WAYS];

  logic                      w_accept;
  logic                      w_chan_ok;
  logic                      w_op_ok;
  logic                      w_legal;
  logic [SET_W+WAY_W-1:0]    w_rd_idx;
  logic [SET_W+WAY_W-1:0]    w_wr_idx;

  // Hold ready low until the first clock after reset release.
  assign d_rc_ready = (r_state == IDLE) && r_rst_done;
  assign w_accept   = d_rc_valid && d_rc_ready;
  assign w_chan_ok  = $onehot(d_rc_channel_1hot_id);
  assign w_op_ok    = (d_rc_op == CACHE_OP_LOAD) || (d_rc_op == CACHE_OP_STORE) ||
                      (d_rc_op == CACHE_OP_WAE);
  assign w_legal    = w_chan_ok && w_op_ok;
  assign w_rd_idx   = {d_rc_set, d_rc_way};
  assign w_wr_idx   = {r_set, r_way};

  assign wbuf_rd_valid       = (r_state == WBUF);
  assign wbuf_rd_id          = r_wbuf_id;
  assign rsp_valid           = (r_state == RESP);
  assign rsp_channel_1hot_id = r_chan;
  assign rsp_rob_id          = r_rob;
  assign rsp_op              = r_op;
  assign rsp_data            = r_rsp_data;
  assign rsp_err             = r_rsp_err;
  assign u_xbar_crdt_rtn     = r_crdt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_state_nxt = (!w_legal || d_rc_op == CACHE_OP_LOAD) ? RESP : WBUF;
        end
      end
      WBUF:    w_state_nxt = WRITE;
      WRITE:   w_state_nxt = RESP;
      RESP:    if (rsp_ready) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rst_done <= 1'b0;
      r_chan     <= '0;
      r_chan_ok  <= 1'b0;
      r_rob      <= '0;
      r_op       <= '0;
      r_set      <= '0;
      r_way      <= '0;
      r_offset   <= '0;
      r_wbuf_id  <= '0;
      r_refill   <= '0;
      r_rsp_data <= '0;
      r_rsp_err  <= 1'b0;
      r_crdt     <= '0;
    end else begin
      r_rst_done <= 1'b1;
      if (w_accept) begin
        r_chan    <= d_rc_channel_1hot_id;
        r_chan_ok <= w_chan_ok;
        r_rob     <= d_rc_rob_id;
        r_op      <= d_rc_op;
        r_set     <= d_rc_set;
        r_way     <= d_rc_way;
        r_offset  <= d_rc_offset;
        r_wbuf_id <= d_rc_wbuf_id;
        r_refill  <= d_rc_refill_data;
        r_rsp_err <= !w_legal;
        if (!w_legal) begin
          r_rsp_data <= '0;
        end else if (d_rc_op == CACHE_OP_LOAD) begin
          r_rsp_data <= r_mem[w_rd_idx][d_rc_offset*WORD_WIDTH +: WORD_WIDTH];
        end
      end
      if (r_state == WRITE) begin
        r_rsp_data <= wbuf_rd_data;
      end
      // Credit pulses the cycle after the response handshake; malformed ids return none.
      r_crdt <= (r_state == RESP && rsp_ready && r_chan_ok) ? r_chan : '0;
    end
  end

  // WAE refills the whole line in WBUF; WRITE then overlays the addressed word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SETS*WAYS; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      if (r_state == WBUF && r_op == CACHE_OP_WAE) begin
        r_mem[w_wr_idx] <= r_refill;
      end
      if (r_state == WRITE) begin
        r_mem[w_wr_idx][r_offset*WORD_WIDTH +: WORD_WIDTH] <= wbuf_rd_data;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_rc_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// tb_rc_ctrl: scoreboard bench for rc_ctrl; expected responses come from a
// behavioural line-array model and a write-buffer responder model.
module tb_rc_ctrl;

  localparam logic [2:0] OP_LOAD  = 3'd0;
  localparam logic [2:0] OP_STORE = 3'd1;
  localparam logic [2:0] OP_WAE   = 3'd2;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         d_rc_valid;
  logic         d_rc_ready;
  logic [2:0]   d_rc_channel_1hot_id;
  logic [3:0]   d_rc_rob_id;
  logic [2:0]   d_rc_op;
  logic [2:0]   d_rc_set;
  logic [1:0]   d_rc_way;
  logic         d_rc_offset;
  logic [6:0]   d_rc_wbuf_id;
  logic [255:0] d_rc_refill_data;
  logic         wbuf_rd_valid;
  logic [6:0]   wbuf_rd_id;
  logic [127:0] wbuf_rd_data;
  logic         rsp_valid;
  logic         rsp_ready;
  logic [2:0]   rsp_channel_1hot_id;
  logic [3:0]   rsp_rob_id;
  logic [2:0]   rsp_op;
  logic [127:0] rsp_data;
  logic         rsp_err;
  logic [2:0]   u_xbar_crdt_rtn;

  rc_ctrl u_dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .d_rc_valid          (d_rc_valid),
    .d_rc_ready          (d_rc_ready),
    .d_rc_channel_1hot_id(d_rc_channel_1hot_id),
    .d_rc_rob_id         (d_rc_rob_id),
    .d_rc_op             (d_rc_op),
    .d_rc_set            (d_rc_set),
    .d_rc_way            (d_rc_way),
    .d_rc_offset         (d_rc_offset),
    .d_rc_wbuf_id        (d_rc_wbuf_id),
    .d_rc_refill_data    (d_rc_refill_data),
    .wbuf_rd_valid       (wbuf_rd_valid),
    .wbuf_rd_id          (wbuf_rd_id),
    .wbuf_rd_data        (wbuf_rd_data),
    .rsp_valid           (rsp_valid),
    .rsp_ready           (rsp_ready),
    .rsp_channel_1hot_id (rsp_channel_1hot_id),
    .rsp_rob_id          (rsp_rob_id),
    .rsp_op              (rsp_op),
    .rsp_data            (rsp_data),
    .rsp_err             (rsp_err),
    .u_xbar_crdt_rtn     (u_xbar_crdt_rtn)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0]   chan;
    logic [3:0]   rob;
    logic [2:0]   op;
    logic [127:0] data;
    logic         err;
  } rsp_t;

  rsp_t         exp_q[$];
  logic [127:0] wbuf_mem [128];
  logic [255:0] model [32];
  int           n_vec = 0;
  int           n_err = 0;

  // Write buffer answers exactly one cycle after the strobe, zero otherwise.
  always @(posedge clk) wbuf_rd_data <= wbuf_rd_valid ? wbuf_mem[wbuf_rd_id] : 128'h0;

  task automatic predict(input logic [2:0] chan, input logic [3:0] rob, input logic [2:0] op,
                         input logic [2:0] set, input logic [1:0] way, input logic off,
                         input logic [6:0] wb, input logic [255:0] refill, output rsp_t e);
    logic [4:0] idx;
    idx = {set, way};
    e = '{chan: chan, rob: rob, op: op, data: 128'h0, err: 1'b0};
    if (!$onehot(chan) || op > OP_WAE) begin
      e.err = 1'b1;
    end else if (op == OP_LOAD) begin
      e.data = off ? model[idx][255:128] : model[idx][127:0];
    end else begin
      if (op == OP_WAE) model[idx] = refill;
      if (off) model[idx][255:128] = wbuf_mem[wb];
      else     model[idx][127:0]   = wbuf_mem[wb];
      e.data = wbuf_mem[wb];
    end
  endtask

  task automatic issue(input logic [2:0] chan, input logic [3:0] rob, input logic [2:0] op,
                       input logic [2:0] set, input logic [1:0] way, input logic off,
                       input logic [6:0] wb, input logic [255:0] refill);
    int n;
    n = 0;
    while (d_rc_ready !== 1'b1 && n < 20) begin
      @(posedge clk); #1; n++;
    end
    if (n >= 20) begin
      n_vec++; n_err++;
      $display("FAIL issue_ready_timeout: d_rc_ready=%b after %0d cycles, required 1", d_rc_ready, n);
    end
    d_rc_channel_1hot_id = chan; d_rc_rob_id = rob; d_rc_op = op; d_rc_set = set;
    d_rc_way = way; d_rc_offset = off; d_rc_wbuf_id = wb; d_rc_refill_data = refill;
    d_rc_valid = 1'b1;
    @(posedge clk); #1;
    d_rc_valid = 1'b0;
  endtask

  // Waits (bounded) for rsp_valid; lat stays -1 if it never comes.
  task automatic collect(output rsp_t got, output int lat, output int wb_cnt,
                         output logic [6:0] wb_id, output int wb_lat);
    lat = -1; wb_cnt = 0; wb_id = '0; wb_lat = -1;
    for (int c = 1; c <= 20; c++) begin
      if (wbuf_rd_valid) begin wb_cnt++; wb_id = wbuf_rd_id; wb_lat = c; end
      if (rsp_valid) begin lat = c; break; end
      @(posedge clk); #1;
    end
    got = {rsp_channel_1hot_id, rsp_rob_id, rsp_op, rsp_data, rsp_err};
  endtask

  task automatic finish_rsp(output logic [2:0] c1, output logic [2:0] c2,
                            output logic v1, output logic r1);
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    c1 = u_xbar_crdt_rtn; v1 = rsp_valid; r1 = d_rc_ready;
    @(posedge clk); #1;
    c2 = u_xbar_crdt_rtn;
  endtask

  task automatic do_txn(input logic [2:0] chan, input logic [3:0] rob, input logic [2:0] op,
                        input logic [2:0] set, input logic [1:0] way, input logic off,
                        input logic [6:0] wb, input logic [255:0] refill,
                        output rsp_t got, output rsp_t exp, output int lat, output int wb_cnt,
                        output logic [6:0] wb_id, output int wb_lat,
                        output logic [2:0] c1, output logic [2:0] c2);
    rsp_t e;
    logic v1, r1;
    predict(chan, rob, op, set, way, off, wb, refill, e);
    exp_q.push_back(e);
    issue(chan, rob, op, set, way, off, wb, refill);
    collect(got, lat, wb_cnt, wb_id, wb_lat);
    exp = exp_q.pop_front();
    finish_rsp(c1, c2, v1, r1);
  endtask

  rsp_t got, exp;
  int lat, wb_cnt, wb_lat;
  logic [6:0] wb_id;
  logic [2:0] c1, c2;

  task automatic test_reset();
    rst_n = 1'b0; rsp_ready = 1'b0; d_rc_valid = 1'b0;
    d_rc_channel_1hot_id = '0; d_rc_rob_id = '0; d_rc_op = '0; d_rc_set = '0;
    d_rc_way = '0; d_rc_offset = '0; d_rc_wbuf_id = '0; d_rc_refill_data = '0;
    for (int i = 0; i < 32; i++) model[i] = '0;
    repeat (3) @(posedge clk);
    #1;
    n_vec++;
    if ({d_rc_ready, rsp_valid, wbuf_rd_valid, u_xbar_crdt_rtn} !== 6'b0) begin
      n_err++;
      $display("FAIL reset_ctrl: ready/rsp_valid/wbuf_valid/crdt=%b required 0",
               {d_rc_ready, rsp_valid, wbuf_rd_valid, u_xbar_crdt_rtn});
    end
    n_vec++;
    if ({rsp_channel_1hot_id, rsp_rob_id, rsp_op, rsp_data, rsp_err} !== '0) begin
      n_err++;
      $display("FAIL reset_rsp_fields: got %h required 0",
               {rsp_channel_1hot_id, rsp_rob_id, rsp_op, rsp_data, rsp_err});
    end
    rst_n = 1'b1;
    #1;
    n_vec++;
    if (d_rc_ready !== 1'b0) begin
      n_err++; $display("FAIL reset_ready_pre_clk: got %b required 0", d_rc_ready);
    end
    @(posedge clk); #1;
    n_vec++;
    if (d_rc_ready !== 1'b1) begin
      n_err++; $display("FAIL reset_ready_post_clk: got %b required 1", d_rc_ready);
    end
  endtask

  task automatic test_load();
    do_txn(3'b001, 4'd2, OP_LOAD, 3'd0, 2'd0, 1'b0, 7'd0, '0, got, exp, lat, wb_cnt, wb_id, wb_lat, c1, c2);
    n_vec++;
    if (got !== exp) begin n_err++; $display("FAIL load_rsp: got %h required %h", got, exp); end
    n_vec++;
    if (lat !== 1) begin n_err++; $display("FAIL load_latency: got %0d required 1", lat); end
    n_vec++;
    if ({c1, c2} !== {3'b001, 3'b000}) begin
      n_err++; $display("FAIL load_credit: got %b,%b required 001,000", c1, c2);
    end
  endtask

  task automatic test_wae();
    wbuf_mem[7] = 128'h1234;
    do_txn(3'b010, 4'd3, OP_WAE, 3'd5, 2'd3, 1'b1, 7'd7, 256'hdddd_eeee_dddd_eeee,
           got, exp, lat, wb_cnt, wb_id, wb_lat, c1, c2);
    n_vec++;
    if (got !== exp) begin n_err++; $display("FAIL wae_rsp: got %h required %h", got, exp); end
    n_vec++;
    if (lat !== 3) begin n_err++; $display("FAIL wae_latency: got %0d required 3", lat); end
    n_vec++;
    if ({wb_cnt, wb_id, wb_lat} !== {32'd1, 7'd7, 32'd1}) begin
      n_err++; $display("FAIL wae_wbuf_strobe: count %0d id %0d cycle %0d required 1/7/1", wb_cnt, wb_id, wb_lat);
    end
    n_vec++;
    if ({c1, c2} !== {3'b010, 3'b000}) begin
      n_err++; $display("FAIL wae_credit: got %b,%b required 010,000", c1, c2);
    end
    do_txn(3'b001, 4'd4, OP_LOAD, 3'd5, 2'd3, 1'b1, 7'd0, '0, got, exp, lat, wb_cnt, wb_id, wb_lat, c1, c2);
    n_vec++;
    if (got !== exp || got.data !== 128'h1234) begin
      n_err++; $display("FAIL wae_load_off1: got %h required %h", got, exp);
    end
    do_txn(3'b001, 4'd5, OP_LOAD, 3'd5, 2'd3, 1'b0, 7'd0, '0, got, exp, lat, wb_cnt, wb_id, wb_lat, c1, c2);
    n_vec++;
    if (got !== exp || got.data !== 128'hdddd_eeee_dddd_eeee) begin
      n_err++; $display("FAIL wae_load_off0: got %h required %h", got, exp);
    end
  endtask

  task automatic test_store();
    wbuf_mem[9] = 128'h7777;
    wbuf_mem[8] = 128'hffff_eeee;
    do_txn(3'b001, 4'd6, OP_WAE, 3'd6, 2'd2, 1'b0, 7'd9, {128'haaaa_0001, 128'h5555_0000},
           got, exp, lat, wb_cnt, wb_id, wb_lat, c1, c2);
    do_txn(3'b100, 4'd5, OP_STORE, 3'd6, 2'd2, 1'b0, 7'd8, {256{1'b1}},
           got, exp, lat, wb_cnt, wb_id, wb_lat, c1, c2);
    n_vec++;
    if (got !== exp || got.op !== OP_STORE) begin
      n_err++; $display("FAIL store_rsp: got %h required %h", got, exp);
    end
    n_vec++;
    if ({lat, wb_id} !== {32'd3, 7'd8}) begin
      n_err++; $display("FAIL store_timing: latency %0d wbuf id %0d required 3/8", lat, wb_id);
    end
    n_vec++;
    if ({c1, c2} !== {3'b100, 3'b000}) begin
      n_err++; $display("FAIL store_credit: got %b,%b required 100,000", c1, c2);
    end
    do_txn(3'b001, 4'd7, OP_LOAD, 3'd6, 2'd2, 1'b0, 7'd0, '0, got, exp, lat, wb_cnt, wb_id, wb_lat, c1, c2);
    n_vec++;
    if (got !== exp || got.data !== 128'hffff_eeee) begin
      n_err++; $display("FAIL store_load_word: got %h required %h", got, exp);
    end
    do_txn(3'b001, 4'd8, OP_LOAD, 3'd6, 2'd2, 1'b1, 7'd0, '0, got, exp, lat, wb_cnt, wb_id, wb_lat, c1, c2);
    n_vec++;
    if (got !== exp || got.data !== 128'haaaa_0001) begin
      n_err++; $display("FAIL store_other_word: got %h required %h", got, exp);
    end
  endtask

  task automatic test_backpressure();
    rsp_t e;
    logic v1, r1;
    predict(3'b001, 4'd9, OP_LOAD, 3'd5, 2'd3, 1'b1, 7'd0, '0, e);
    exp_q.push_back(e);
    issue(3'b001, 4'd9, OP_LOAD, 3'd5, 2'd3, 1'b1, 7'd0, '0);
    collect(got, lat, wb_cnt, wb_id, wb_lat);
    exp = exp_q.pop_front();
    n_vec++;
    if (got !== exp || lat !== 1) begin
      n_err++; $display("FAIL bp_rsp: got %h lat %0d required %h lat 1", got, lat, exp);
    end
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      n_vec++;
      if ({rsp_valid, d_rc_ready, u_xbar_crdt_rtn, rsp_channel_1hot_id, rsp_rob_id, rsp_op, rsp_data, rsp_err}
          !== {1'b1, 1'b0, 3'b000, exp}) begin
        n_err++;
        $display("FAIL bp_hold_%0d: valid %b ready %b crdt %b rsp %h required 1 0 000 %h", i,
                 rsp_valid, d_rc_ready, u_xbar_crdt_rtn,
                 {rsp_channel_1hot_id, rsp_rob_id, rsp_op, rsp_data, rsp_err}, exp);
      end
    end
    finish_rsp(c1, c2, v1, r1);
    n_vec++;
    if ({c1, c2, v1, r1} !== {3'b001, 3'b000, 1'b0, 1'b1}) begin
      n_err++; $display("FAIL bp_release: crdt %b,%b valid %b ready %b required 001,000 0 1", c1, c2, v1, r1);
    end
  endtask

  task automatic test_back_to_back();
    rsp_t e;
    rsp_ready = 1'b1;
    predict(3'b010, 4'd10, OP_LOAD, 3'd5, 2'd3, 1'b0, 7'd0, '0, e);
    exp_q.push_back(e);
    issue(3'b010, 4'd10, OP_LOAD, 3'd5, 2'd3, 1'b0, 7'd0, '0);
    got = {rsp_channel_1hot_id, rsp_rob_id, rsp_op, rsp_data, rsp_err};
    exp = exp_q.pop_front();
    n_vec++;
    if ({rsp_valid, d_rc_ready, got} !== {1'b1, 1'b0, exp}) begin
      n_err++; $display("FAIL b2b_first: valid %b ready %b rsp %h required 1 0 %h", rsp_valid, d_rc_ready, got, exp);
    end
    @(posedge clk); #1;
    n_vec++;
    if ({rsp_valid, d_rc_ready, u_xbar_crdt_rtn} !== {1'b0, 1'b1, 3'b010}) begin
      n_err++; $display("FAIL b2b_turnaround: valid %b ready %b crdt %b required 0 1 010", rsp_valid, d_rc_ready, u_xbar_crdt_rtn);
    end
    predict(3'b100, 4'd11, OP_LOAD, 3'd6, 2'd2, 1'b0, 7'd0, '0, e);
    exp_q.push_back(e);
    issue(3'b100, 4'd11, OP_LOAD, 3'd6, 2'd2, 1'b0, 7'd0, '0);
    got = {rsp_channel_1hot_id, rsp_rob_id, rsp_op, rsp_data, rsp_err};
    exp = exp_q.pop_front();
    n_vec++;
    if ({rsp_valid, got} !== {1'b1, exp}) begin
      n_err++; $display("FAIL b2b_second: valid %b rsp %h required 1 %h", rsp_valid, got, exp);
    end
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    n_vec++;
    if (u_xbar_crdt_rtn !== 3'b100) begin
      n_err++; $display("FAIL b2b_second_credit: got %b required 100", u_xbar_crdt_rtn);
    end
  endtask

  task automatic test_illegal();
    do_txn(3'b011, 4'd12, OP_LOAD, 3'd5, 2'd3, 1'b1, 7'd0, '0, got, exp, lat, wb_cnt, wb_id, wb_lat, c1, c2);
    n_vec++;
    if (got !== exp || got.err !== 1'b1 || got.data !== 128'h0) begin
      n_err++; $display("FAIL illegal_chan_rsp: got %h required %h", got, exp);
    end
    n_vec++;
    if ({lat, wb_cnt, c1, c2} !== {32'd1, 32'd0, 3'b000, 3'b000}) begin
      n_err++; $display("FAIL illegal_chan_side: lat %0d wbuf %0d crdt %b,%b required 1 0 000,000", lat, wb_cnt, c1, c2);
    end
    do_txn(3'b001, 4'd13, 3'd5, 3'd5, 2'd3, 1'b1, 7'd7, '0, got, exp, lat, wb_cnt, wb_id, wb_lat, c1, c2);
    n_vec++;
    if (got !== exp || wb_cnt !== 0 || c1 !== 3'b001) begin
      n_err++; $display("FAIL illegal_op: got %h wbuf %0d crdt %b required %h 0 001", got, wb_cnt, c1, exp);
    end
    do_txn(3'b001, 4'd14, OP_LOAD, 3'd5, 2'd3, 1'b1, 7'd0, '0, got, exp, lat, wb_cnt, wb_id, wb_lat, c1, c2);
    n_vec++;
    if (got !== exp || got.data !== 128'h1234) begin
      n_err++; $display("FAIL illegal_array_kept: got %h required %h", got, exp);
    end
  endtask

  task automatic test_reset_midop();
    wbuf_mem[10] = 128'hbeef;
    issue(3'b001, 4'd1, OP_STORE, 3'd5, 2'd3, 1'b1, 7'd10, '0);
    n_vec++;
    if (wbuf_rd_valid !== 1'b1) begin
      n_err++; $display("FAIL midop_in_wbuf: wbuf_rd_valid %b required 1", wbuf_rd_valid);
    end
    rst_n = 1'b0;
    for (int i = 0; i < 32; i++) model[i] = '0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      n_vec++;
      if ({rsp_valid, u_xbar_crdt_rtn, d_rc_ready, wbuf_rd_valid} !== 6'b0) begin
        n_err++; $display("FAIL midop_in_reset_%0d: valid/crdt/ready/wbuf %b required 0", i,
                          {rsp_valid, u_xbar_crdt_rtn, d_rc_ready, wbuf_rd_valid});
      end
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    n_vec++;
    if ({d_rc_ready, rsp_valid, u_xbar_crdt_rtn} !== {1'b1, 1'b0, 3'b000}) begin
      n_err++; $display("FAIL midop_release: ready %b valid %b crdt %b required 1 0 000", d_rc_ready, rsp_valid, u_xbar_crdt_rtn);
    end
    do_txn(3'b001, 4'd2, OP_LOAD, 3'd5, 2'd3, 1'b1, 7'd0, '0, got, exp, lat, wb_cnt, wb_id, wb_lat, c1, c2);
    n_vec++;
    if (got !== exp || got.data !== 128'h0) begin
      n_err++; $display("FAIL midop_cleared_5_3_1: got %h required %h", got, exp);
    end
    do_txn(3'b010, 4'd3, OP_LOAD, 3'd6, 2'd2, 1'b1, 7'd0, '0, got, exp, lat, wb_cnt, wb_id, wb_lat, c1, c2);
    n_vec++;
    if (got !== exp || got.data !== 128'h0) begin
      n_err++; $display("FAIL midop_cleared_6_2_1: got %h required %h", got, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_load();
    test_wae();
    test_store();
    test_backpressure();
    test_back_to_back();
    test_illegal();
    test_reset_midop();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/rc_ctrl.md
Name: rc_ctrl

Overview:
- Responder end of the ISU-to-read-cache (d_rc) interface.
- Accepts one issued cache operation at a time from the ISU and executes it against a local data array of SETS x WAYS lines:
  - LOAD: word read
  - STORE: word write, with the data fetched from the write buffer
  - WAE: full-line refill write, then merge of a write-buffer word
- Returns the result on a per-channel response port and pulses the crossbar credit-return vector the ISU consumes.

Parameters:
SETS, 8, number of sets; SET_W = log2(SETS) = 3
WAYS, 4, ways per set; WAY_W = log2(WAYS) = 2
CL_WIDTH, 256, cache line width in bits
WORD_WIDTH, 128, word width; OFF_W = log2(CL_WIDTH/WORD_WIDTH) = 1
ROB_W, 4, ROB id width
WBUF_W, 7, write buffer id width
CHAN, 3, number of channels (one-hot id width)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
d_rc_valid  in  1  request valid
d_rc_ready  out  1  request ready
d_rc_channel_1hot_id  in  CHAN  originating channel, one-hot
d_rc_rob_id  in  ROB_W  ROB tag, echoed in the response
d_rc_op  in  3  CACHE_OP_LOAD / CACHE_OP_STORE / CACHE_OP_WAE (mpc_types encoding)
d_rc_set  in  SET_W  target set
d_rc_way  in  WAY_W  target way
d_rc_offset  in  OFF_W  word offset within the line
d_rc_wbuf_id  in  WBUF_W  write-buffer entry holding store data
d_rc_refill_data  in  CL_WIDTH  refill line (WAE only)
wbuf_rd_valid  out  1  write-buffer read strobe
wbuf_rd_id  out  WBUF_W  write-buffer entry to read
wbuf_rd_data  in  WORD_WIDTH  read data, valid exactly 1 cycle after the strobe
rsp_valid  out  1  response valid
rsp_ready  in  1  response ready
rsp_channel_1hot_id  out  CHAN  echoed channel
rsp_rob_id  out  ROB_W  echoed ROB id
rsp_op  out  3  echoed op
rsp_data  out  WORD_WIDTH  load data, or the written word for STORE/WAE
rsp_err  out  1  illegal request flag
u_xbar_crdt_rtn  out  CHAN  credit return, one-cycle pulse per channel

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; all request registers cleared; data array cleared to 0.
  - d_rc_ready=0 while in reset; d_rc_ready=1 from the first clock after deassertion.
  - rsp_valid, rsp_err, wbuf_rd_valid, u_xbar_crdt_rtn = 0; rsp_* fields = 0.
  - Reset mid-operation aborts the operation. No response and no credit are produced for it.
- Line layout: offset 0 = bits [127:0]; offset 1 = bits [255:128].
- Handshake:
  - A request is accepted when d_rc_valid & d_rc_ready.
  - d_rc_ready = (state==IDLE); at most one request is outstanding.
  - All request fields are captured on accept.
- FSM states: IDLE, WBUF, WRITE, RESP.
- IDLE, on accept (cycle T):
  - Illegal request (channel id not exactly one-hot, or op not LOAD/STORE/WAE): go to RESP with rsp_err=1 and rsp_data=0. No array or wbuf access.
  - LOAD: rsp_data <= array[set][way] word[offset]; go to RESP. rsp_valid is high at T+1.
  - STORE or WAE: go to WBUF.
- WBUF (T+1):
  - wbuf_rd_valid=1 and wbuf_rd_id=captured wbuf_id, for exactly one cycle.
  - WAE only: array[set][way] <= captured refill_data at the end of this cycle.
  - Next state: WRITE.
- WRITE (T+2):
  - array[set][way] word[offset] <= wbuf_rd_data; rsp_data <= wbuf_rd_data.
  - Only the addressed word is written; the other word of a WAE line keeps the refill value.
  - Next state: RESP. rsp_valid is high at T+3.
- RESP:
  - rsp_valid=1; all rsp_* fields hold stable until rsp_ready.
  - On rsp_valid & rsp_ready: return to IDLE next cycle.
  - Credit: u_xbar_crdt_rtn = captured channel vector in the cycle after the handshake, for one cycle. The pulse is all-zero if the channel id was not one-hot.
- Throughput with rsp_ready held high:
  - One LOAD per 2 cycles (accept T, response T+1, accept T+2).
  - One STORE/WAE per 4 cycles.
- A LOAD immediately after a STORE/WAE to the same word returns the newly written data; the write completes before RESP.
- d_rc_valid with d_rc_ready=0 is ignored; the requester must hold it.
- Fields other than the echoed ones are don't-care for LOAD; d_rc_refill_data is ignored for LOAD and STORE.

Test Plan:
- Reset then LOAD of set 0, way 0, offset 0, channel 3'b001, rob 2 -> rsp_valid at T+1, rsp_data=0, rsp_rob_id=2, rsp_err=0, u_xbar_crdt_rtn=3'b001 one cycle after the response handshake.
- WAE on channel 3'b010: set 5, way 3, offset 1, wbuf 7, refill 'hdddd_eeee_dddd_eeee, with wbuf returning 'h1234 -> wbuf_rd_valid with id 7 at T+1, rsp_data='h1234 at T+3.
  - Follow-up LOAD of set 5 / way 3 / offset 1 returns 'h1234.
  - Follow-up LOAD of offset 0 returns 'hdddd_eeee_dddd_eeee.
- STORE on channel 3'b100: set 6, way 2, offset 0, wbuf 8 returning 'hffff_eeee -> response with rsp_op=STORE and crdt=3'b100.
  - LOAD of the same word returns 'hffff_eeee.
  - The offset 1 word of that line is unchanged.
- Backpressure: rsp_ready=0 for 5 cycles after a LOAD -> rsp_* held stable, d_rc_ready=0, no credit; then rsp_ready=1 gives exactly one response and one credit pulse.
- Illegal request: channel 3'b011, op LOAD -> rsp_err=1, rsp_data=0, u_xbar_crdt_rtn=0, array unchanged.
- rst_n asserted in the WBUF state of a STORE -> no response, no credit, array all zero, d_rc_ready=1 on the first clock after reset release.
